// File: rtl/udp_echo_responder_if.sv
// udp_echo_responder_if: UDP receive and transmit header+payload stream bundles
interface udp_rx_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] source_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    modport master (output hdr_valid, source_ip, source_port, dest_port, tdata, tvalid, tlast, tuser,
                    input hdr_ready, tready);
    modport slave  (input hdr_valid, source_ip, source_port, dest_port, tdata, tvalid, tlast, tuser,
                    output hdr_ready, tready);
endinterface

interface udp_tx_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] dest_ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    modport master (output hdr_valid, dest_ip, source_port, dest_port, length, tdata, tvalid, tlast, tuser,
                    input hdr_ready, tready);
    modport slave  (input hdr_valid, dest_ip, source_port, dest_port, length, tdata, tvalid, tlast, tuser,
                    output hdr_ready, tready);
endinterface

// File: rtl/udp_echo_responder.sv
// udp_echo_responder: store-and-forward UDP echo with port filter, error/oversize drop and prefetched replay
module udp_echo_responder #(
    parameter logic [15:0] LISTEN_PORT = 16'd1234,
    parameter int          DEPTH       = 2048
) (
    input  logic        clk,
    input  logic        reset,
    udp_rx_if.slave     s_udp,
    udp_tx_if.master    m_udp,
    output logic [15:0] frames_echoed,
    output logic [15:0] frames_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [2:0] IDLE = 3'd0, STORE = 3'd1, DROP = 3'd2, HDR = 3'd3, SEND = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [AW:0] cnt_q, cnt_d, rd_ptr_q, rd_ptr_d;
    logic        ovf_q, ovf_d;
    logic [31:0] ip_q, ip_d;
    logic [15:0] sp_q, sp_d, dp_q, dp_d, len_q, len_d;
    logic [15:0] echoed_q, echoed_d, dropped_q, dropped_d;
    logic        pend_q, pend_d, pend_last_q, pend_last_d;
    logic        out_v_q, out_v_d, out_l_q, out_l_d;
    logic [7:0]  out_d_q, out_d_d, rdata_q;
    logic [7:0]  mem [DEPTH];
    logic        beat, tx_fire, adv, ren, wr_en;

    assign s_udp.hdr_ready = (state_q == IDLE) && !reset;
    assign s_udp.tready    = (state_q == STORE) || (state_q == DROP);
    assign beat            = s_udp.tvalid && s_udp.tready;
    assign m_udp.hdr_valid   = state_q == HDR;
    assign m_udp.dest_ip     = ip_q;
    assign m_udp.source_port = dp_q;
    assign m_udp.dest_port   = sp_q;
    assign m_udp.length      = len_q;
    assign m_udp.tdata       = out_d_q;
    assign m_udp.tvalid      = out_v_q && (state_q == SEND);
    assign m_udp.tlast       = out_l_q && (state_q == SEND);
    assign m_udp.tuser       = 1'b0;
    assign tx_fire = m_udp.tvalid && m_udp.tready;
    // Prefetch runs from HDR onward so the first byte is already waiting when the header is taken.
    assign adv = !out_v_q || tx_fire;
    assign ren = ((state_q == HDR) || (state_q == SEND)) && (rd_ptr_q != cnt_q) && (!pend_q || adv);
    assign wr_en = (state_q == STORE) && beat && (cnt_q != FULL);
    assign frames_echoed  = echoed_q;
    assign frames_dropped = dropped_q;

    // Frame state machine: filter, store, header, replay.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        ip_d      = ip_q;
        sp_d      = sp_q;
        dp_d      = dp_q;
        len_d     = len_q;
        echoed_d  = echoed_q;
        dropped_d = dropped_q;
        rd_ptr_d  = ren ? rd_ptr_q + ONE : rd_ptr_q;
        case (state_q)
            IDLE: if (s_udp.hdr_valid) begin
                if (s_udp.dest_port == LISTEN_PORT) begin
                    ip_d    = s_udp.source_ip;
                    sp_d    = s_udp.source_port;
                    dp_d    = s_udp.dest_port;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = STORE;
                end else begin
                    state_d = DROP;
                end
            end
            STORE: if (beat) begin
                cnt_d = wr_en ? cnt_q + ONE : cnt_q;
                ovf_d = ovf_q || !wr_en;
                if (s_udp.tlast) begin
                    if (s_udp.tuser || ovf_d) begin
                        dropped_d = dropped_q + 16'd1;
                        state_d   = IDLE;
                    end else begin
                        len_d    = 16'(cnt_d) + 16'd8;
                        rd_ptr_d = '0;
                        state_d  = HDR;
                    end
                end
            end
            DROP: if (beat && s_udp.tlast) begin
                dropped_d = dropped_q + 16'd1;
                state_d   = IDLE;
            end
            HDR: if (m_udp.hdr_ready) state_d = SEND;
            SEND: if (tx_fire && out_l_q) begin
                echoed_d = echoed_q + 16'd1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-stage read pipeline: RAM output register feeding the output beat register.
    always_comb begin
        pend_d      = ren || (pend_q && !adv);
        pend_last_d = ren ? (rd_ptr_q == cnt_q - ONE) : pend_last_q;
        out_v_d     = adv ? pend_q : out_v_q;
        out_d_d     = (adv && pend_q) ? rdata_q : out_d_q;
        out_l_d     = (adv && pend_q) ? pend_last_q : out_l_q;
    end

    // Payload buffer: write while storing, synchronous read held when not re-read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cnt_q[AW-1:0]] <= s_udp.tdata;
        if (ren) rdata_q <= mem[rd_ptr_q[AW-1:0]];
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            ovf_q       <= 1'b0;
            ip_q        <= '0;
            sp_q        <= '0;
            dp_q        <= '0;
            len_q       <= '0;
            echoed_q    <= '0;
            dropped_q   <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            out_v_q     <= 1'b0;
            out_l_q     <= 1'b0;
            out_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            ip_q        <= ip_d;
            sp_q        <= sp_d;
            dp_q        <= dp_d;
            len_q       <= len_d;
            echoed_q    <= echoed_d;
            dropped_q   <= dropped_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            out_v_q     <= out_v_d;
            out_l_q     <= out_l_d;
            out_d_q     <= out_d_d;
        end
    end
endmodule

// File: doc/udp_echo_responder.md
# udp_echo_responder

Store-and-forward UDP echo stage between the UDP receive output and the UDP transmit input of the UDP/IP stack. It accepts received UDP headers and payloads, filters them by destination port, and buffers each accepted payload in full. Only complete, error-free frames are echoed: the block emits a reply header with swapped ports, the sender's IP as destination, and the recomputed length, then replays the payload. Frames that are dropped or oversized never reach the transmit path.

## Interface
Parameters:
- LISTEN_PORT, 16'd1234, UDP destination port accepted for echo; all others dropped
- DEPTH, 2048, payload buffer size in bytes (power of two, ≤ 65527)

Ports:
- clk  in  1  clock for all logic and both streams
- reset  in  1  synchronous, active-high reset
- s_udp_hdr_valid / s_udp_hdr_ready  in / out  1 / 1  receive header handshake
- s_udp_ip_source_ip  in  32  sender IP
- s_udp_source_port, s_udp_dest_port  in  16 each  received ports
- s_udp_payload_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  receive payload; tuser=1 on the tlast beat marks a bad frame
- m_udp_hdr_valid / m_udp_hdr_ready  out / in  1 / 1  transmit header handshake
- m_udp_ip_dest_ip  out  32  reply destination IP (= latched sender IP)
- m_udp_source_port, m_udp_dest_port  out  16 each  reply ports (swapped)
- m_udp_length  out  16  payload bytes + 8
- m_udp_payload_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  transmit payload; tuser always 0
- frames_echoed, frames_dropped  out  16 each  wrapping event counters

## Operation
- States: IDLE, STORE, DROP, HDR, SEND.
- IDLE: s_udp_hdr_ready=1. On header handshake:
  - dest_port == LISTEN_PORT: latch source IP, source port and dest port; clear byte count and overflow flag; go to STORE.
  - otherwise: go to DROP.
- STORE: s_udp_payload_tready=1.
  - Each accepted beat with count < DEPTH: write the byte to the buffer at address count, then increment count.
  - A beat arriving with count == DEPTH: discard the byte and set overflow.
  - On the tlast beat:
    - tuser=1 or overflow set: increment frames_dropped, go to IDLE.
    - otherwise: go to HDR. The tlast byte is stored if space remains.
- DROP: s_udp_payload_tready=1, beats discarded. On tlast: increment frames_dropped, go to IDLE.
- HDR: m_udp_hdr_valid=1, with fields held stable until handshake:
  - m_udp_ip_dest_ip = latched source IP
  - m_udp_source_port = latched dest_port
  - m_udp_dest_port = latched source_port
  - m_udp_length = count + 8 (16-bit)
  - On handshake go to SEND.
- SEND: replay buffer addresses 0..count-1 in order.
  - m_udp_payload_tlast=1 only on address count-1.
  - On the tlast handshake: increment frames_echoed, go to IDLE.
- s_udp_hdr_ready=0 in every state except IDLE. s_udp_payload_tready=0 outside STORE and DROP.
- The buffer is a single-port-read, synchronous-read RAM; a one-entry output register (prefetch) hides the read latency.
- Counters wrap from 0xFFFF to 0.

## Timing
- Reset values:
  - state IDLE
  - all valid outputs 0, m_udp_payload_tlast 0, tuser 0
  - s_udp_hdr_ready 0 during reset, 1 from the first cycle after reset deasserts
  - s_udp_payload_tready 0
  - header fields 0, counters 0
- Reset mid-frame aborts with no output and no counter change. The remainder of an in-flight input frame is then processed as header-less payload: in IDLE it is not accepted (tready=0).
- Header handshake in IDLE → STORE or DROP on the next cycle; tready rises that same cycle.
- Last stored beat → m_udp_hdr_valid asserted on the next cycle.
- m_udp_hdr handshake → m_udp_payload_tvalid asserted within 2 cycles.
- SEND sustains 1 byte/cycle while tready=1.
- Backpressure: tdata, tlast and tvalid hold while tvalid=1 and tready=0; no byte is skipped or repeated.
- Frame with tlast beat alone (1 byte): m_udp_length = 9, single output beat with tlast=1.
- Exactly DEPTH bytes: echoed with m_udp_length = DEPTH+8. DEPTH+1 bytes: dropped.
- Store-and-forward boundary: a new input header is not accepted until SEND completes.

## Test plan
- Port filter accept: header from IP 192.168.1.10, ports 5000→1234, payload 0x01..0x04 with tlast on 0x04 → reply header dest_ip 0xC0A8010A, ports 1234→5000, length 12; payload 01 02 03 04 with tlast on 04; frames_echoed=1.
- Port filter reject: dest_port 80, 10-byte payload → all 10 beats accepted, no m_udp_hdr_valid, frames_dropped=1.
- Error frame: 6-byte frame to port 1234 with tuser=1 on the last beat → no output, frames_dropped=1; the next good frame echoes correctly.
- Size boundaries: DEPTH bytes → echoed, length DEPTH+8. DEPTH+1 bytes → dropped. 1 byte → length 9, single tlast beat.
- Backpressure: random m_udp_payload_tready (50%) during a 64-byte echo → output equals input byte-for-byte, stable while stalled; header held until hdr_ready.
- Reset in SEND after 3 of 8 bytes → all outputs at reset values next cycle, counters 0, s_udp_hdr_ready=1 after reset release.
